csa_resolve_sat: RTL and testbench

CSA_RESOLVE_SAT -- requirements
Module: csa_resolve_sat

---
 rtl/csa_resolve_sat.sv | 119 +++++++++++
 tb/tb_csa_resolve_sat.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_sat.sv
// csa_resolve_sat: two-stage carry-propagate resolve of a carry-save pair
// (s_in + 2*c_in) with clip-to-pixel, saturation flag, edge compare and a
// sticky saturation counter, behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    input beat handshake (in_ready is combinational)
//   s_in, c_in, thresh    sum vector, unshifted carry vector, edge threshold
//   out_valid, out_ready  result beat handshake
//   sum_out               exact s_in + 2*c_in (W+2 bits)
//   pix_out               sum_out clipped to 2^W-1
//   sat_out, edge_out     clip happened / pix_out >= thresh
//   sat_cnt, cnt_clr      delivered saturated beats (sticky at max), sync clear
module csa_resolve_sat #(
    parameter int W     = 8,
    parameter int SPLIT = W / 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   s_in,
    input  logic [W-1:0]   c_in,
    input  logic [W-1:0]   thresh,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   sum_out,
    output logic [W-1:0]   pix_out,
    output logic           sat_out,
    output logic           edge_out,
    output logic [15:0]    sat_cnt,
    input  logic           cnt_clr
);

    // Width of the upper partial sum completed in stage 2.
    localparam int HW = W + 2 - SPLIT;

    logic             v1;
    logic [SPLIT-1:0] lo1;
    logic             cy1;
    logic [W-SPLIT-1:0] s_hi1;
    logic [W-SPLIT:0] c_hi1;
    logic [W-1:0]     th1;
    logic             v2;

    logic             ld1;
    logic             ld2;
    logic             out_hs;

    assign in_ready  = !v1 || !v2 || out_ready;
    assign ld1       = in_ready;
    assign ld2       = !v2 || out_ready;
    assign out_valid = v2;
    assign out_hs    = v2 && out_ready;

    // Lower partial add. The carry vector is shifted left by one, so its
    // bit 0 contribution is zero and c_in[SPLIT-1] belongs to the upper half.
    logic [SPLIT:0] lo_add;
    assign lo_add = {1'b0, s_in[SPLIT-1:0]}
                  + {1'b0, c_in[SPLIT-2:0], 1'b0};

    logic [HW-1:0]  hi_add;
    logic [W+1:0]   sum_nx;
    logic           sat_nx;
    logic [W-1:0]   pix_nx;
    logic           edge_nx;

    assign hi_add  = HW'(s_hi1) + HW'(c_hi1) + HW'(cy1);
    assign sum_nx  = {hi_add, lo1};
    assign sat_nx  = |sum_nx[W+1:W];
    assign pix_nx  = sat_nx ? {W{1'b1}} : sum_nx[W-1:0];
    assign edge_nx = pix_nx >= th1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            lo1   <= '0;
            cy1   <= 1'b0;
            s_hi1 <= '0;
            c_hi1 <= '0;
            th1   <= '0;
        end else if (ld1) begin
            v1    <= in_valid;
            lo1   <= lo_add[SPLIT-1:0];
            cy1   <= lo_add[SPLIT];
            s_hi1 <= s_in[W-1:SPLIT];
            c_hi1 <= c_in[W-1:SPLIT-1];
            th1   <= thresh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            sum_out  <= '0;
            pix_out  <= '0;
            sat_out  <= 1'b0;
            edge_out <= 1'b0;
        end else if (ld2) begin
            v2       <= v1;
            sum_out  <= sum_nx;
            pix_out  <= pix_nx;
            sat_out  <= sat_nx;
            edge_out <= edge_nx;
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (cnt_clr) begin
            sat_cnt <= '0;
        end else if (out_hs && sat_out && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_csa_resolve_sat.sv
// tb_csa_resolve_sat: directed self-checking bench for csa_resolve_sat.
// Linear directed steps; every comparison is an immediate assertion.
module tb_csa_resolve_sat;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   s_in = '0;
    logic [W-1:0]   c_in = '0;
    logic [W-1:0]   thresh = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W+1:0]   sum_out;
    logic [W-1:0]   pix_out;
    logic           sat_out;
    logic           edge_out;
    logic [15:0]    sat_cnt;
    logic           cnt_clr = 1'b0;

    int n_pass = 0;
    int n_tot  = 0;

    csa_resolve_sat #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .c_in      (c_in),
        .thresh    (thresh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .pix_out   (pix_out),
        .sat_out   (sat_out),
        .edge_out  (edge_out),
        .sat_cnt   (sat_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] q_sum[$];
    logic [7:0] q_thr[$];
    int         sent;
    int         got;
    int         exp_cnt;
    logic       hold;
    logic       hs_in;
    logic       hs_out;
    logic [9:0] h_sum;
    logic [7:0] h_pix;
    logic       h_sat;
    logic       h_edge;
    logic [9:0] e_sum;
    logic [7:0] e_thr;
    logic [7:0] e_pix;

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Carry crosses the split point
        in_valid = 1'b1; out_ready = 1'b1;
        s_in = 8'h0F; c_in = 8'h01; thresh = 8'h20;
        tick();
        in_valid = 1'b0;
        chk("lat_c1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("v1_valid", 32'(out_valid), 32'd1);
        chk("v1_sum", 32'(sum_out), 32'h011);
        chk("v1_pix", 32'(pix_out), 32'h11);
        chk("v1_sat", 32'(sat_out), 32'd0);
        chk("v1_edge", 32'(edge_out), 32'd0);
        tick();
        chk("v1_drained", 32'(out_valid), 32'd0);
        chk("v1_cnt", 32'(sat_cnt), 32'd0);

        // Maximum operands, saturating, edge at equality
        in_valid = 1'b1;
        s_in = 8'hFF; c_in = 8'hFF; thresh = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        chk("v2_valid", 32'(out_valid), 32'd1);
        chk("v2_sum", 32'(sum_out), 32'h2FD);
        chk("v2_pix", 32'(pix_out), 32'hFF);
        chk("v2_sat", 32'(sat_out), 32'd1);
        chk("v2_edge", 32'(edge_out), 32'd1);
        chk("v2_cnt_before", 32'(sat_cnt), 32'd0);
        tick();
        chk("v2_cnt_after", 32'(sat_cnt), 32'd1);

        // Stream of 16 beats with random backpressure
        sent = 0; got = 0; exp_cnt = 1; hold = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            in_valid  = (sent < 16);
            s_in      = 8'(sent * 37 + 5);
            c_in      = 8'(sent * 53 + 11);
            thresh    = 8'(sent * 16);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("st_in_ready", 32'(in_ready),
                32'(!(q_sum.size() == 2 && !out_ready)));
            if (hold) begin
                chk("st_hold_valid", 32'(out_valid), 32'd1);
                chk("st_hold_sum", 32'(sum_out), 32'(h_sum));
                chk("st_hold_pix", 32'(pix_out), 32'(h_pix));
                chk("st_hold_flags", 32'({sat_out, edge_out}),
                    32'({h_sat, h_edge}));
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                if (q_sum.size() == 0) begin
                    chk("st_spurious", 32'd1, 32'(q_sum.size()));
                end else begin
                    e_sum = q_sum.pop_front();
                    e_thr = q_thr.pop_front();
                    e_pix = (e_sum > 10'd255) ? 8'hFF : e_sum[7:0];
                    chk("st_sum", 32'(sum_out), 32'(e_sum));
                    chk("st_pix", 32'(pix_out), 32'(e_pix));
                    chk("st_sat", 32'(sat_out), 32'(e_sum > 10'd255));
                    chk("st_edge", 32'(edge_out), 32'(e_pix >= e_thr));
                    if (e_sum > 10'd255) exp_cnt++;
                end
                got++;
            end
            hold   = out_valid && !out_ready;
            h_sum  = sum_out;
            h_pix  = pix_out;
            h_sat  = sat_out;
            h_edge = edge_out;
            @(posedge clk);
            #1;
            if (hs_in) begin
                q_sum.push_back(10'(s_in) + 10'(c_in) * 10'd2);
                q_thr.push_back(thresh);
                sent++;
            end
        end
        in_valid = 1'b0;
        chk("st_count", 32'(got), 32'd16);
        chk("st_sat_cnt", 32'(sat_cnt), 32'(exp_cnt));

        // Sticky counter at all-ones, then clear racing an increment
        out_ready = 1'b1;
        tick();
        chk("st_drained", 32'(out_valid), 32'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_alone", 32'(sat_cnt), 32'd0);
        s_in = 8'hFF; c_in = 8'hFF; thresh = 8'h00;
        in_valid = 1'b1;
        repeat (65535) tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("fill_drained", 32'(out_valid), 32'd0);
        chk("fill_cnt", 32'(sat_cnt), 32'hFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("extra_valid", 32'(out_valid), 32'd1);
        tick();
        chk("no_wrap", 32'(sat_cnt), 32'hFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("race_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_wins", 32'(sat_cnt), 32'd0);
        chk("clr_consumed", 32'(out_valid), 32'd0);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        s_in = 8'h10; c_in = 8'h10; thresh = 8'h00;
        in_valid = 1'b1;
        tick();
        s_in = 8'h20;
        tick();
        in_valid = 1'b0;
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_sum", 32'(sum_out), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("flush_c1", 32'(out_valid), 32'd0);
        tick();
        chk("flush_c2", 32'(out_valid), 32'd0);
        s_in = 8'h03; c_in = 8'h02; thresh = 8'h07;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_c1", 32'(out_valid), 32'd0);
        tick();
        chk("post_valid", 32'(out_valid), 32'd1);
        chk("post_sum", 32'(sum_out), 32'h007);
        chk("post_edge", 32'(edge_out), 32'd1);
        chk("post_cnt", 32'(sat_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
